// File: rtl/timer_cmp_irq.sv
// timer_cmp_irq: compare-match interrupt unit sitting beside a free-running
// timer. Holds CTRL/CMP/PERIOD/STATUS registers on a simple write-strobe bus
// and raises a level interrupt when the timer count equals CMP.
//
// Bus handshake: a write is a single-cycle i_we pulse with i_addr/i_wdata
// valid in that cycle; there is no ready/backpressure, every write is
// accepted on the rising edge it is presented. Reads are combinational from
// i_addr and reflect the registered state.
module timer_cmp_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0100
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_timer_val,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq,
  output logic [1:0]  o_dbg_state
);

  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h0;
  localparam logic [31:0] ADDR_CMP    = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_PERIOD = BASE_ADDR + 32'h8;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'hC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;     // [0] EN, [1] PERIODIC, [2] IE
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] period_q, period_d;
  logic        pend_q, pend_d;
  logic [7:0]  ovr_q, ovr_d;

  logic wr_ctrl, wr_cmp, wr_period, wr_status;
  logic disable_wr, w1c, match, reload;

  // Write decode and match qualification
  always_comb begin
    wr_ctrl    = i_we && (i_addr == ADDR_CTRL);
    wr_cmp     = i_we && (i_addr == ADDR_CMP);
    wr_period  = i_we && (i_addr == ADDR_PERIOD);
    wr_status  = i_we && (i_addr == ADDR_STATUS);
    disable_wr = wr_ctrl && !i_wdata[0];
    w1c        = wr_status && i_wdata[0];
    // A disabling CTRL write on the same edge swallows the match entirely.
    match      = (state_q == ST_ARMED) && (i_timer_val == cmp_q) && !disable_wr;
    reload     = match && ctrl_q[1] && (period_q != 32'd0);
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    period_d = period_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;

    case (state_q)
      ST_IDLE:  if (wr_ctrl && i_wdata[0]) state_d = ST_ARMED;
      ST_ARMED: if (match && !reload)      state_d = ST_FIRED;
      ST_FIRED: if (wr_cmp && ctrl_q[0])   state_d = ST_ARMED;
      default:                             state_d = ST_IDLE;
    endcase
    if (disable_wr) state_d = ST_IDLE;

    if (wr_ctrl)   ctrl_d   = i_wdata[2:0];
    if (wr_period) period_d = i_wdata;

    // Bus write to CMP wins over the periodic reload.
    if (reload) cmp_d = cmp_q + period_q;
    if (wr_cmp) cmp_d = i_wdata;

    // Clear first; a match on the same edge re-sets PEND but does not count
    // as an overrun because the clear already consumed the old event.
    if (w1c) begin
      pend_d = 1'b0;
      ovr_d  = 8'd0;
    end
    if (match) begin
      pend_d = 1'b1;
      if (pend_q && !w1c && (ovr_q != 8'd255)) ovr_d = ovr_q + 8'd1;
    end
  end

  // State and register flops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 3'd0;
      cmp_q    <= 32'd0;
      period_q <= 32'd0;
      pend_q   <= 1'b0;
      ovr_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      cmp_q    <= cmp_d;
      period_q <= period_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  // Combinational read mux and registered-only interrupt output
  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      ADDR_CTRL:   o_rdata = {29'd0, ctrl_q};
      ADDR_CMP:    o_rdata = cmp_q;
      ADDR_PERIOD: o_rdata = period_q;
      ADDR_STATUS: o_rdata = {16'd0, ovr_q, 5'd0, state_q, pend_q};
      default:     o_rdata = 32'd0;
    endcase
    o_irq       = pend_q & ctrl_q[2];
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed bench for timer_cmp_irq. The bench owns the timer count and
// advances it by one per clock when running, so every match edge is known.
module tb_timer_cmp_irq;

  localparam logic [31:0] BASE   = 32'h1000_0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_CMP  = BASE + 32'h4;
  localparam logic [31:0] A_PER  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk;
  logic        rst;
  logic [31:0] tval;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  dbg_state;

  logic        timer_run;
  int          n_checks;
  int          n_fail;

  timer_cmp_irq #(.BASE_ADDR(BASE)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_timer_val (tval),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rdata     (rdata),
    .o_irq       (irq),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Driver tasks: inputs change 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (timer_run) tval = tval + 32'd1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic run_to(input logic [31:0] v);
    int budget;
    budget = 5000;
    while (tval != v && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (tval != v) begin
      n_fail++;
      $display("FAIL run_to: timer %h never reached %h", tval, v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    timer_run = 1'b0;
    tval = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    #1;
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d); end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    do_reset();
    bus_read(A_CMP, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_cmp: got %h want 0", d); end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    do_reset();
    bus_write(A_CMP, 32'd100);
    bus_write(A_CTRL, 32'h5);
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL os_ctrl_rb: got %h want 5", d); end
    tval = 32'd0;
    timer_run = 1'b1;
    run_to(32'd100);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_irq_early: got %b want 0", irq); end
    step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL os_irq: got %b want 1", irq); end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL os_status: got %h want 5", d); end
    bus_write(A_STAT, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_w1c_irq: got %b want 0", irq); end
    // Wrap the timer through 100 again: FIRED must ignore it.
    tval = 32'hFFFF_FFF0;
    repeat (150) step();
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h4 || irq !== 1'b0) begin
      n_fail++; $display("FAIL os_no_rematch: status %h irq %b want 4/0", d, irq);
    end
    // CMP write while enabled re-arms from FIRED.
    bus_write(A_CMP, 32'd200);
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL os_rearm: got %h want 2", d); end
    run_to(32'd200);
    step();
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL os_refire: got %h want 5", d); end
  endtask

  task automatic test_periodic_wrap();
    logic [31:0] d;
    do_reset();
    bus_write(A_CMP, 32'hFFFF_FFF0);
    bus_write(A_PER, 32'h20);
    bus_write(A_CTRL, 32'h7);
    tval = 32'hFFFF_FFEE;
    timer_run = 1'b1;
    run_to(32'hFFFF_FFF0);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL pw_irq_early: got %b want 0", irq); end
    step();
    bus_read(A_CMP, d);
    n_checks++;
    if (d !== 32'h0000_0010) begin n_fail++; $display("FAIL pw_cmp_wrap: got %h want 10", d); end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL pw_status: got %h want 3", d); end
    bus_write(A_STAT, 32'h1);
    run_to(32'h10);
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL pw_pre_match: got %h want 2", d); end
    step();
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h3 || irq !== 1'b1) begin
      n_fail++; $display("FAIL pw_second_match: status %h irq %b want 3/1", d, irq);
    end
    bus_read(A_CMP, d);
    n_checks++;
    if (d !== 32'h30) begin n_fail++; $display("FAIL pw_cmp_next: got %h want 30", d); end
  endtask

  task automatic test_overrun_and_simul();
    logic [31:0] d;
    do_reset();
    bus_write(A_CMP, 32'd3);
    bus_write(A_PER, 32'd4);
    bus_write(A_CTRL, 32'h7);
    tval = 32'd0;
    timer_run = 1'b1;
    run_to(32'd39);   // 10th match at 3 + 4*9
    step();
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h0903) begin n_fail++; $display("FAIL ovr_9: got %h want 903", d); end
    run_to(32'd1199); // 300th match at 3 + 4*299
    step();
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'hFF03) begin n_fail++; $display("FAIL ovr_sat: got %h want ff03", d); end
    bus_read(A_CMP, d);
    n_checks++;
    if (d !== 32'd1203) begin n_fail++; $display("FAIL ovr_cmp: got %0d want 1203", d); end
    bus_write(A_STAT, 32'h1);
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h2 || irq !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clear: status %h irq %b want 2/0", d, irq);
    end
    // Build PEND=1, OVR=1, then W1C on the match edge at 1211.
    run_to(32'd1207);
    step();
    run_to(32'd1211);
    bus_write(A_STAT, 32'h1);
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL simul_w1c: got %h want 3", d); end
    // Clear, then disable exactly on the match edge at 1215.
    bus_write(A_STAT, 32'h1);
    run_to(32'd1215);
    bus_write(A_CTRL, 32'h0);
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL simul_disable: status %h state %0d want 0/0", d, dbg_state);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d;
    do_reset();
    bus_write(A_CMP, 32'd5);
    bus_write(A_PER, 32'd10);
    bus_write(A_CTRL, 32'h7);
    tval = 32'd0;
    timer_run = 1'b1;
    run_to(32'd5);
    step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_pre_irq: got %b want 1", irq); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_async_irq: got %b want 0", irq); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    timer_run = 1'b0;
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL mid_ctrl: got %h want 0", d); end
    bus_read(A_CMP, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL mid_cmp: got %h want 0", d); end
    bus_read(A_PER, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL mid_period: got %h want 0", d); end
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL mid_status: got %h want 0", d); end
  endtask

  task automatic test_decode_and_ie();
    logic [31:0] d;
    do_reset();
    bus_write(A_CMP, 32'd7);
    bus_write(A_PER, 32'd3);
    bus_write(A_CTRL, 32'h3);   // EN + PERIODIC, IE off
    bus_write(BASE + 32'h10, 32'hDEAD_BEEF);
    bus_read(BASE + 32'h10, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL dec_unmapped: got %h want 0", d); end
    bus_read(A_CMP, d);
    n_checks++;
    if (d !== 32'd7) begin n_fail++; $display("FAIL dec_cmp_kept: got %h want 7", d); end
    bus_read(A_PER, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL dec_per_kept: got %h want 3", d); end
    bus_write(A_CTRL, 32'hFFFF_FFFB); // upper bits ignored, IE=0
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL dec_ctrl_mask: got %h want 3", d); end
    tval = 32'd0;
    timer_run = 1'b1;
    run_to(32'd7);
    step();
    bus_read(A_STAT, d);
    n_checks++;
    if (d !== 32'h3 || irq !== 1'b0) begin
      n_fail++; $display("FAIL ie_off: status %h irq %b want 3/0", d, irq);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    we        = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    tval      = 32'd0;
    timer_run = 1'b0;
    test_reset();
    test_one_shot();
    test_periodic_wrap();
    test_overrun_and_simul();
    test_reset_mid_op();
    test_decode_and_ie();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
